// File: rtl/anti_theft_if.sv
// Signal bundle between the vehicle sensors (master) and the anti-theft controller (slave).
// No handshake: level inputs plus a 1 Hz tick strobe, registered status outputs.
interface anti_theft_if;
    logic       tick;
    logic       ignition;
    logic       door_driver;
    logic       door_pass;
    logic       siren;
    logic       status_led;
    logic       armed;
    logic [2:0] state;

    modport master (
        output tick, ignition, door_driver, door_pass,
        input  siren, status_led, armed, state
    );

    modport slave (
        input  tick, ignition, door_driver, door_pass,
        output siren, status_led, armed, state
    );
endinterface

// File: rtl/anti_theft_fsm.sv
// Vehicle arming/alarm controller: entry delay, siren hold-off, re-arm after departure.
// Latency 1 cycle from sampled input to state/outputs; no backpressure, inputs are sampled every cycle.
module anti_theft_fsm #(
    parameter int unsigned T_ARM       = 6,
    parameter int unsigned T_DRIVER    = 8,
    parameter int unsigned T_PASSENGER = 15,
    parameter int unsigned T_ALARM     = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic         clock,
    input  logic         reset,
    anti_theft_if.slave  bus
);

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        TRIGGERED  = 3'd1,
        SOUND      = 3'd2,
        DISARMED   = 3'd3,
        WAIT_OPEN  = 3'd4,
        WAIT_CLOSE = 3'd5,
        ARM_DELAY  = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               siren_q, siren_d;
    logic               led_q, led_d;
    logic               armed_q, armed_d;
    logic               door_any;
    logic               expired;

    assign door_any = bus.door_driver | bus.door_pass;
    assign expired  = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        // Free-running countdown; any load below overrides, so a coincident tick is dropped.
        cnt_d   = (bus.tick && !expired) ? cnt_q - CNT_W'(1) : cnt_q;

        if (bus.ignition && state_q != DISARMED) begin
            state_d = DISARMED;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (bus.door_driver) begin
                        state_d = TRIGGERED;
                        cnt_d   = CNT_W'(T_DRIVER);
                    end else if (bus.door_pass) begin
                        state_d = TRIGGERED;
                        cnt_d   = CNT_W'(T_PASSENGER);
                    end
                end
                TRIGGERED: begin
                    if (expired) begin
                        state_d = SOUND;
                        cnt_d   = CNT_W'(T_ALARM);
                    end
                end
                SOUND: begin
                    if (door_any) begin
                        cnt_d = CNT_W'(T_ALARM);
                    end else if (expired) begin
                        state_d = ARMED;
                    end
                end
                DISARMED: begin
                    if (!bus.ignition) state_d = WAIT_OPEN;
                end
                WAIT_OPEN: begin
                    if (bus.door_driver) state_d = WAIT_CLOSE;
                end
                WAIT_CLOSE: begin
                    if (!door_any) begin
                        state_d = ARM_DELAY;
                        cnt_d   = CNT_W'(T_ARM);
                    end
                end
                ARM_DELAY: begin
                    if (door_any)     state_d = WAIT_CLOSE;
                    else if (expired) state_d = ARMED;
                end
                default: state_d = ARMED;
            endcase
        end

        siren_d = (state_d == SOUND);
        armed_d = (state_d == ARMED);
        // Blink only while staying in ARMED; entering ARMED always starts dark.
        if (state_d == TRIGGERED || state_d == SOUND) begin
            led_d = 1'b1;
        end else if (state_d == ARMED && state_q == ARMED) begin
            led_d = led_q ^ bus.tick;
        end else begin
            led_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARMED;
            cnt_q   <= '0;
            siren_q <= 1'b0;
            led_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            siren_q <= siren_d;
            led_q   <= led_d;
            armed_q <= armed_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.siren      = siren_q;
    assign bus.status_led = led_q;
    assign bus.armed      = armed_q;

endmodule

// File: doc/anti_theft_fsm.md
# anti_theft_fsm

Arming and alarm controller for the vehicle security system. It watches the doors and the ignition, arms the car after the driver leaves, runs the entry-delay countdown when a door opens on an armed car, and drives the siren and status LED. It sits beside `fuel_pump`, sharing the `ignition` input. The 1 Hz `tick` comes from the system divider.

## Interface
- `T_ARM`, 6: seconds from driver door closing to re-armed.
- `T_DRIVER`, 8: entry delay in seconds, driver door.
- `T_PASSENGER`, 15: entry delay in seconds, passenger door.
- `T_ALARM`, 10: seconds the siren sounds after the last door closes.
- `CNT_W`, 4: countdown width. Every `T_*` must be ≤ 2^CNT_W−1.

Ports:
- `clock` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-`clock`-wide pulse, once per second.
- `ignition` in 1: key on.
- `door_driver` in 1: driver door open.
- `door_pass` in 1: passenger door open.
- `siren` out 1: horn drive.
- `status_led` out 1: dashboard LED.
- `armed` out 1: high in ARMED only.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encodings:
  - ARMED=0
  - TRIGGERED=1
  - SOUND=2
  - DISARMED=3
  - WAIT_OPEN=4
  - WAIT_CLOSE=5
  - ARM_DELAY=6
- Countdown `cnt` (CNT_W bits):
  - Loaded on state entry where noted.
  - Decrements on `tick` when nonzero; holds at 0.
  - "Expired" means `cnt==0` in the current cycle.
- Ignition rule: in every state except DISARMED, `ignition`=1 forces DISARMED next cycle. This takes priority over all other conditions.
- Transitions:
  - ARMED:
    - `door_driver` → TRIGGERED, load T_DRIVER.
    - Else `door_pass` → TRIGGERED, load T_PASSENGER.
    - If both doors open, the driver door wins.
  - TRIGGERED:
    - Expired → SOUND, load T_ALARM.
    - Doors closing does not cancel the countdown.
  - SOUND:
    - Any door open → reload T_ALARM every cycle. The reload wins over a coincident `tick`.
    - Expired with both doors closed → ARMED.
  - DISARMED: `ignition`=0 → WAIT_OPEN.
  - WAIT_OPEN: `door_driver` → WAIT_CLOSE.
  - WAIT_CLOSE: `door_driver`=0 and `door_pass`=0 → ARM_DELAY, load T_ARM.
  - ARM_DELAY:
    - Any door open → WAIT_CLOSE.
    - Else expired → ARMED.
- Outputs (registered, updated with state):
  - `siren` = 1 only in SOUND.
  - `armed` = 1 only in ARMED.
  - `status_led` toggles on each `tick` in ARMED (0.5 Hz blink).
  - `status_led` is steady 1 in TRIGGERED and SOUND.
  - `status_led` is 0 in all other states, and is cleared on leaving ARMED.
- Inputs are assumed already synchronised and debounced upstream.

## Timing
- Reset, when `reset`=1 at a clock edge:
  - state=ARMED, `cnt`=0.
  - `siren`=0, `status_led`=0, `armed`=1 on the following cycle.
  - Reset mid-countdown or mid-siren aborts immediately; no residual siren.
- Transition latency: an input change sampled at edge N shows on `state` and the outputs after edge N.
- Timed states take exactly T ticks. The exit happens on the first edge where `cnt==0`, which is the edge after the T-th tick.
- T=0 exits one cycle after entry.
- `tick` coinciding with a state load: the load wins and that tick is not counted.
- `tick` held high for several cycles is a misuse. `cnt` decrements once per cycle the pulse is high.

## Test plan
Bench uses default parameters and `tick` every 4 clocks.

1. Reset then idle, doors closed, ignition off:
   - state=0, `armed`=1.
   - `status_led` toggles on each tick.
   - `siren`=0 indefinitely.
2. From ARMED, pulse `door_driver` 1 cycle:
   - state=1 next cycle.
   - state=2 and `siren`=1 after 8 ticks.
   - Back to 0 after 10 further ticks, `siren`=0.
3. From ARMED, open `door_pass` for 3 cycles, then set `ignition`=1 after 5 ticks:
   - state=1 for those 5 ticks.
   - state=3 next cycle, `siren` never asserted.
4. In SOUND, hold `door_pass`=1 for 30 ticks, then close:
   - `siren` stays 1 throughout.
   - Returns to ARMED exactly 10 ticks after closing.
5. Departure sequence: ignition 1→0, driver door open, driver door close:
   - state 3→4→5→6.
   - ARMED after 6 ticks.
   - Opening `door_pass` at tick 4 returns to 5 and restarts the 6-tick delay after it closes.
6. Assert `reset` for 1 cycle while in SOUND with `cnt`=7:
   - Next cycle state=0, `siren`=0, `cnt`=0.
   - Asserting `ignition` plus both doors in the same cycle from ARMED gives DISARMED.
